// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, hcount/vcount raster counters, horizontal/vertical
// phase FSMs, and registered sync, visible-area, line/frame strobes and a frame counter.
module vga_timing_gen #(
   parameter int   CLK_DIV   = 2,
   parameter int   H_VISIBLE = 640,
   parameter int   H_FRONT   = 16,
   parameter int   H_SYNC    = 96,
   parameter int   H_BACK    = 48,
   parameter int   V_VISIBLE = 480,
   parameter int   V_FRONT   = 10,
   parameter int   V_SYNC    = 2,
   parameter int   V_BACK    = 33,
   parameter logic SYNC_POL  = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   output logic        pix_tick,
   output logic [9:0]  hcount,
   output logic [9:0]  vcount,
   output logic        hsync,
   output logic        vsync,
   output logic        video_on,
   output logic        line_start,
   output logic        frame_start,
   output logic [15:0] frame_count
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0] H_ACT_END = 10'(H_VISIBLE - 1);
   localparam logic [9:0] H_FP_END  = 10'(H_VISIBLE + H_FRONT - 1);
   localparam logic [9:0] H_SY_END  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_ACT_END = 10'(V_VISIBLE - 1);
   localparam logic [9:0] V_FP_END  = 10'(V_VISIBLE + V_FRONT - 1);
   localparam logic [9:0] V_SY_END  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);

   localparam logic SYNC_ON  = SYNC_POL;
   localparam logic SYNC_OFF = ~SYNC_POL;

   typedef enum logic [1:0] {H_ACT, H_FP, H_SY, H_BP} h_state_t;
   typedef enum logic [1:0] {V_ACT, V_FP, V_SY, V_BP} v_state_t;

   h_state_t          h_state_q, h_state_d;
   v_state_t          v_state_q, v_state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              tick_q, tick_d;
   logic [9:0]        h_q, h_d;
   logic [9:0]        v_q, v_d;
   logic [15:0]       fc_q, fc_d;
   logic              hsync_q, vsync_q, video_q, ls_q, fs_q;
   logic              h_wrap, v_wrap;

   always_comb begin
      div_d     = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      tick_d    = (div_q == DIV_LAST);
      h_wrap    = tick_q && (h_q == H_LAST);
      v_wrap    = h_wrap && (v_q == V_LAST);
      h_d       = h_q;
      v_d       = v_q;
      fc_d      = fc_q;
      h_state_d = h_state_q;
      v_state_d = v_state_q;

      if (tick_q) h_d = h_wrap ? 10'd0 : h_q + 1'b1;
      if (h_wrap) v_d = v_wrap ? 10'd0 : v_q + 1'b1;
      if (v_wrap) fc_d = fc_q + 1'b1;

      // Phase transitions fire on the same edge the counter crosses each boundary.
      if (tick_q) begin
         case (h_state_q)
            H_ACT:   if (h_q == H_ACT_END) h_state_d = H_FP;
            H_FP:    if (h_q == H_FP_END)  h_state_d = H_SY;
            H_SY:    if (h_q == H_SY_END)  h_state_d = H_BP;
            H_BP:    if (h_q == H_LAST)    h_state_d = H_ACT;
            default: h_state_d = H_ACT;
         endcase
      end
      if (h_wrap) begin
         case (v_state_q)
            V_ACT:   if (v_q == V_ACT_END) v_state_d = V_FP;
            V_FP:    if (v_q == V_FP_END)  v_state_d = V_SY;
            V_SY:    if (v_q == V_SY_END)  v_state_d = V_BP;
            V_BP:    if (v_q == V_LAST)    v_state_d = V_ACT;
            default: v_state_d = V_ACT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q     <= '0;
         tick_q    <= 1'b0;
         h_q       <= '0;
         v_q       <= '0;
         fc_q      <= '0;
         h_state_q <= H_ACT;
         v_state_q <= V_ACT;
         hsync_q   <= SYNC_OFF;
         vsync_q   <= SYNC_OFF;
         video_q   <= 1'b0;
         ls_q      <= 1'b0;
         fs_q      <= 1'b0;
      end else begin
         div_q     <= div_d;
         tick_q    <= tick_d;
         h_q       <= h_d;
         v_q       <= v_d;
         fc_q      <= fc_d;
         h_state_q <= h_state_d;
         v_state_q <= v_state_d;
         // Decodes use next-state values so they line up with the counters they describe.
         hsync_q   <= (h_state_d == H_SY) ? SYNC_ON : SYNC_OFF;
         vsync_q   <= (v_state_d == V_SY) ? SYNC_ON : SYNC_OFF;
         video_q   <= (h_state_d == H_ACT) && (v_state_d == V_ACT);
         ls_q      <= h_wrap;
         fs_q      <= v_wrap;
      end
   end

   assign pix_tick    = tick_q;
   assign hcount      = h_q;
   assign vcount      = v_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_q;
   assign line_start  = ls_q;
   assign frame_start = fs_q;
   assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a 640x480 instance plus a tiny-geometry instance (CLK_DIV=1) so frame
// wraps fit in a short run; expected values are queued per post-reset cycle and popped by a monitor.
module tb_vga_timing_gen;

   localparam int F_TICK = 0, F_H = 1, F_V = 2, F_HS = 3, F_VS = 4,
                  F_VID = 5, F_LS = 6, F_FS = 7, F_FC = 8;

   typedef struct {
      int    cyc;
      int    fld;
      int    val;
      string name;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   passed = 0;
   exp_t qm[$];
   exp_t qs[$];

   logic        m_tick, m_hs, m_vs, m_vid, m_ls, m_fs;
   logic [9:0]  m_h, m_v;
   logic [15:0] m_fc;
   logic        s_tick, s_hs, s_vs, s_vid, s_ls, s_fs;
   logic [9:0]  s_h, s_v;
   logic [15:0] s_fc;

   always #5 clk = ~clk;

   vga_timing_gen #(.CLK_DIV(2)) dut (
      .clk(clk), .reset(reset), .pix_tick(m_tick), .hcount(m_h), .vcount(m_v),
      .hsync(m_hs), .vsync(m_vs), .video_on(m_vid), .line_start(m_ls),
      .frame_start(m_fs), .frame_count(m_fc)
   );

   vga_timing_gen #(
      .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_POL(1'b0)
   ) dut_s (
      .clk(clk), .reset(reset), .pix_tick(s_tick), .hcount(s_h), .vcount(s_v),
      .hsync(s_hs), .vsync(s_vs), .video_on(s_vid), .line_start(s_ls),
      .frame_start(s_fs), .frame_count(s_fc)
   );

   // Post-reset edge count; pixel P of the main instance is shown in cycles 2P+1 and 2P+2.
   always @(posedge clk) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   function automatic int get_val(input bit sm, input int f);
      case (f)
         F_TICK:  return sm ? int'(s_tick) : int'(m_tick);
         F_H:     return sm ? int'(s_h)    : int'(m_h);
         F_V:     return sm ? int'(s_v)    : int'(m_v);
         F_HS:    return sm ? int'(s_hs)   : int'(m_hs);
         F_VS:    return sm ? int'(s_vs)   : int'(m_vs);
         F_VID:   return sm ? int'(s_vid)  : int'(m_vid);
         F_LS:    return sm ? int'(s_ls)   : int'(m_ls);
         F_FS:    return sm ? int'(s_fs)   : int'(m_fs);
         default: return sm ? int'(s_fc)   : int'(m_fc);
      endcase
   endfunction

   task automatic compare(input bit sm, input exp_t e);
      int act;
      act = get_val(sm, e.fld);
      checks++;
      if (e.cyc != cyc)
         $display("FAIL %s%s: checked at cyc %0d, required at cyc %0d",
                  sm ? "s." : "m.", e.name, cyc, e.cyc);
      else if (act != e.val)
         $display("FAIL %s%s: got %0d, expected %0d (cyc %0d)",
                  sm ? "s." : "m.", e.name, act, e.val, cyc);
      else
         passed++;
   endtask

   always @(negedge clk) begin
      while (qm.size() > 0 && qm[0].cyc <= cyc) compare(1'b0, qm.pop_front());
      while (qs.size() > 0 && qs[0].cyc <= cyc) compare(1'b1, qs.pop_front());
   end

   task automatic pm(input int c, input int f, input int v, input string n);
      exp_t e;
      e.cyc = c; e.fld = f; e.val = v; e.name = n;
      qm.push_back(e);
   endtask

   task automatic ps(input int c, input int f, input int v, input string n);
      exp_t e;
      e.cyc = c; e.fld = f; e.val = v; e.name = n;
      qs.push_back(e);
   endtask

   task automatic push_reset_state();
      pm(0, F_TICK, 0, "rst_tick"); pm(0, F_H, 0, "rst_h");   pm(0, F_V, 0, "rst_v");
      pm(0, F_HS, 1, "rst_hs");     pm(0, F_VS, 1, "rst_vs"); pm(0, F_VID, 0, "rst_vid");
      pm(0, F_LS, 0, "rst_ls");     pm(0, F_FS, 0, "rst_fs"); pm(0, F_FC, 0, "rst_fc");
      ps(0, F_TICK, 0, "rst_tick"); ps(0, F_H, 0, "rst_h");   ps(0, F_V, 0, "rst_v");
      ps(0, F_HS, 1, "rst_hs");     ps(0, F_VS, 1, "rst_vs"); ps(0, F_VID, 0, "rst_vid");
      ps(0, F_FC, 0, "rst_fc");
   endtask

   task automatic push_startup();
      pm(1, F_TICK, 0, "st_tick1"); pm(1, F_H, 0, "st_h1");    pm(1, F_VID, 1, "st_vid1");
      pm(1, F_HS, 1, "st_hs1");     pm(1, F_VS, 1, "st_vs1");  pm(1, F_LS, 0, "st_ls1");
      pm(1, F_FS, 0, "st_fs1");
      pm(2, F_TICK, 1, "st_tick2"); pm(2, F_H, 0, "st_h2");
      pm(3, F_TICK, 0, "st_tick3"); pm(3, F_H, 1, "st_h3");
      pm(4, F_TICK, 1, "st_tick4"); pm(5, F_H, 2, "st_h5");
      ps(1, F_TICK, 1, "st_tick1"); ps(1, F_H, 0, "st_h1");    ps(1, F_VID, 1, "st_vid1");
      ps(2, F_TICK, 1, "st_tick2"); ps(2, F_H, 1, "st_h2");
   endtask

   task automatic release_after_reset_check();
      push_reset_state();
      @(negedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      release_after_reset_check();
      push_startup();

      // Small instance: line/frame/sync/visible boundaries (pixel P shown in cycle P+1).
      ps(9,   F_H, 8, "s_h8");      ps(9,   F_VID, 0, "s_vid_8_0");
      ps(11,  F_H, 10, "s_h10");    ps(11,  F_HS, 0, "s_hs_on");
      ps(14,  F_H, 13, "s_h13");    ps(14,  F_HS, 1, "s_hs_off");
      ps(83,  F_V, 5, "s_v5");      ps(83,  F_VID, 1, "s_vid_7_5");
      ps(91,  F_V, 6, "s_v6");      ps(91,  F_VID, 0, "s_vid_0_6");
      ps(106, F_V, 7, "s_v7");      ps(106, F_VS, 1, "s_vs_v7");
      ps(121, F_V, 8, "s_v8");      ps(121, F_VS, 0, "s_vs_v8");
      ps(150, F_V, 9, "s_v9");      ps(150, F_VS, 0, "s_vs_v9_end");
      ps(151, F_V, 10, "s_v10");    ps(151, F_VS, 1, "s_vs_v10");
      ps(195, F_H, 14, "s_h_last"); ps(195, F_V, 12, "s_v_last");
      ps(195, F_VID, 0, "s_vid_last"); ps(195, F_FS, 0, "s_fs_pre"); ps(195, F_FC, 0, "s_fc_pre");
      ps(196, F_H, 0, "s_h_wrap");  ps(196, F_V, 0, "s_v_wrap");
      ps(196, F_LS, 1, "s_ls_fw");  ps(196, F_FS, 1, "s_fs_fw");
      ps(196, F_FC, 1, "s_fc1");    ps(196, F_VID, 1, "s_vid_0_0");
      ps(197, F_LS, 0, "s_ls_end"); ps(197, F_FS, 0, "s_fs_end");
      ps(391, F_FS, 1, "s_fs_2");   ps(391, F_FC, 2, "s_fc2");

      // Main instance: hsync edges, visible edge, line wraps.
      pm(1279, F_H, 639, "m_h639");  pm(1279, F_VID, 1, "m_vid_639_0");
      pm(1281, F_H, 640, "m_h640");  pm(1281, F_VID, 0, "m_vid_640_0");
      pm(1311, F_H, 655, "m_h655");  pm(1311, F_HS, 1, "m_hs_655");
      pm(1313, F_H, 656, "m_h656");  pm(1313, F_HS, 0, "m_hs_656");
      pm(1313, F_VS, 1, "m_vs_line0");
      pm(1503, F_H, 751, "m_h751");  pm(1503, F_HS, 0, "m_hs_751");
      pm(1505, F_H, 752, "m_h752");  pm(1505, F_HS, 1, "m_hs_752");
      pm(1601, F_H, 0, "m_h_l1");    pm(1601, F_V, 1, "m_v_l1");
      pm(1601, F_LS, 1, "m_ls_l1");  pm(1602, F_LS, 0, "m_ls_l1_end");
      pm(17599, F_H, 799, "m_h799"); pm(17599, F_V, 10, "m_v10"); pm(17599, F_LS, 0, "m_ls_pre");
      pm(17601, F_H, 0, "m_h_l11");  pm(17601, F_V, 11, "m_v11");
      pm(17601, F_LS, 1, "m_ls_l11"); pm(17601, F_FS, 0, "m_fs_l11");
      pm(17602, F_LS, 0, "m_ls_l11_end"); pm(17602, F_H, 0, "m_h_l11b");
      pm(18201, F_H, 300, "m_h300"); pm(18201, F_V, 11, "m_v11b");

      // Mid-frame reset for one edge, then restart must look like the first start-up.
      while (cyc < 18201) @(negedge clk);
      #2 reset = 1'b1;
      @(posedge clk);
      #1;
      release_after_reset_check();
      push_startup();

      for (int i = 0; i < 50 && (qm.size() > 0 || qs.size() > 0); i++) @(negedge clk);
      if (qm.size() > 0 || qs.size() > 0) begin
         $display("FAIL drain: %0d expectations never checked, required 0", qm.size() + qs.size());
         checks += qm.size() + qs.size();
      end
      #2;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: cyc %0d reached time limit, required completion", cyc);
      $fatal(1, "timeout");
   end

endmodule
